// File: rtl/tl_pkg.sv
// Shared traffic-light encoding: phase codes, lamp patterns and the legal phase order.
// Lamp vectors are ordered {reda, yellowa, greena, redb, yellowb, greenb}; a = NS, b = EW.
package tl_pkg;

  typedef enum logic [2:0] {
    PH_EW    = 3'b000,
    PH_EY    = 3'b001,
    PH_NY    = 3'b010,
    PH_NS    = 3'b011,
    PH_BAD   = 3'b100,
    PH_START = 3'b111
  } phase_t;

  localparam logic [5:0] LAMP_START = 6'b100100;
  localparam logic [5:0] LAMP_NS    = 6'b001100;
  localparam logic [5:0] LAMP_NY    = 6'b010100;
  localparam logic [5:0] LAMP_EW    = 6'b100001;
  localparam logic [5:0] LAMP_EY    = 6'b100010;

  // True when to_ph is the one phase allowed to follow from_ph.
  // Nothing may move into START, so START never appears as a target.
  function automatic logic is_successor(phase_t from_ph, phase_t to_ph);
    logic ok;
    ok = 1'b0;
    case (from_ph)
      PH_START: ok = (to_ph == PH_NS);
      PH_NS:    ok = (to_ph == PH_NY);
      PH_NY:    ok = (to_ph == PH_EW);
      PH_EW:    ok = (to_ph == PH_EY);
      PH_EY:    ok = (to_ph == PH_NS);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/tl_lampdecode.sv
// Combinational lamp-pattern to phase-code decode; anything unrecognised is BAD.
module tl_lampdecode
  import tl_pkg::*;
(
  input  logic [5:0] lamps,
  output logic [2:0] phase
);

  // Exact-match decode of the five legal patterns, everything else (dark, both green, ...) is BAD.
  always_comb begin
    phase = PH_BAD;
    case (lamps)
      LAMP_START: phase = PH_START;
      LAMP_NS:    phase = PH_NS;
      LAMP_NY:    phase = PH_NY;
      LAMP_EW:    phase = PH_EW;
      LAMP_EY:    phase = PH_EY;
      default:    phase = PH_BAD;
    endcase
  end

endmodule

// File: rtl/tlmonitor.sv
// Traffic-light lamp monitor: registers the observed lamps, decodes them to a phase,
// measures each phase in slow ticks and raises sticky conflict / sequence / timing flags.
module tlmonitor
  import tl_pkg::*;
#(
  parameter int T_WIDTH = 12,
  parameter int NS_TIME = 90,
  parameter int EW_TIME = 60,
  parameter int Y_TIME  = 30,
  parameter int TOL     = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_clr,
  input  logic               i_reda,
  input  logic               i_yellowa,
  input  logic               i_greena,
  input  logic               i_redb,
  input  logic               i_yellowb,
  input  logic               i_greenb,
  output logic [2:0]         o_phase,
  output logic               o_done,
  output logic [T_WIDTH-1:0] o_last_len,
  output logic               o_err_conflict,
  output logic               o_err_seq,
  output logic               o_err_time
);

  logic [5:0]         lamp_q;
  logic [2:0]         dec_raw;
  phase_t             dec;
  phase_t             cur, cur_next;
  logic [T_WIDTH-1:0] cnt, cnt_next;
  logic [T_WIDTH-1:0] last_len_next;
  logic               done_next;
  logic               conflict_set, seq_set, time_set;
  logic [T_WIDTH:0]   exp_len, len_ext, diff;
  logic               cnt_sat, time_bad;

  // Stage 1: capture the raw lamp pattern; reset looks like the START pattern.
  always_ff @(posedge i_clk) begin
    if (i_rst) lamp_q <= LAMP_START;
    else       lamp_q <= {i_reda, i_yellowa, i_greena, i_redb, i_yellowb, i_greenb};
  end

  tl_lampdecode u_decode (
    .lamps (lamp_q),
    .phase (dec_raw)
  );

  assign dec = phase_t'(dec_raw);

  // Nominal length of the phase being left, widened by one bit so the distance never wraps.
  always_comb begin
    exp_len = '0;
    case (cur)
      PH_NS:        exp_len = (T_WIDTH+1)'(NS_TIME);
      PH_EW:        exp_len = (T_WIDTH+1)'(EW_TIME);
      PH_NY, PH_EY: exp_len = (T_WIDTH+1)'(Y_TIME);
      default:      exp_len = '0;
    endcase
  end

  assign cnt_sat  = (cnt == {T_WIDTH{1'b1}});
  assign len_ext  = {1'b0, cnt};
  assign diff     = (len_ext >= exp_len) ? (len_ext - exp_len) : (exp_len - len_ext);
  assign time_bad = cnt_sat || (diff > (T_WIDTH+1)'(TOL));

  // Stage 2 next-state: on a phase change judge the old/new pair, otherwise count ticks.
  always_comb begin
    cur_next      = cur;
    cnt_next      = cnt;
    last_len_next = o_last_len;
    done_next     = 1'b0;
    conflict_set  = 1'b0;
    seq_set       = 1'b0;
    time_set      = 1'b0;
    if (dec != cur) begin
      done_next     = 1'b1;
      last_len_next = cnt;
      cur_next      = dec;
      cnt_next      = i_tick ? T_WIDTH'(1) : '0;
      if (dec == PH_BAD) conflict_set = 1'b1;
      if (cur != PH_BAD) begin
        if ((dec != PH_BAD) && !is_successor(cur, dec)) seq_set = 1'b1;
        if ((cur != PH_START) && time_bad) time_set = 1'b1;
      end
    end else if (i_tick && !cnt_sat) begin
      cnt_next = cnt + T_WIDTH'(1);
    end
  end

  // Stage 2 registers: phase, counter, report outputs and sticky flags (a new error beats clear).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cur            <= PH_START;
      cnt            <= '0;
      o_last_len     <= '0;
      o_done         <= 1'b0;
      o_err_conflict <= 1'b0;
      o_err_seq      <= 1'b0;
      o_err_time     <= 1'b0;
    end else begin
      cur            <= cur_next;
      cnt            <= cnt_next;
      o_last_len     <= last_len_next;
      o_done         <= done_next;
      o_err_conflict <= (o_err_conflict & ~i_clr) | conflict_set;
      o_err_seq      <= (o_err_seq      & ~i_clr) | seq_set;
      o_err_time     <= (o_err_time     & ~i_clr) | time_set;
    end
  end

  assign o_phase = cur;

endmodule
